// File: rtl/regfile_dump.sv
// ============================================================================
// regfile_dump
// ----------------------------------------------------------------------------
// 32 x 32-bit MIPS general-purpose register file. It has two combinational
// read ports and one write port, plus a dump engine that streams a snapshot
// of registers 0..DUMP_LAST over a valid/ready handshake.
//
// Parameters
//   BYPASS     1: a same-cycle write is forwarded to qa/qb.
//              0: reads return the stored value only.
//   DUMP_LAST  index of the last register streamed by the dump (0..31).
//
// Ports
//   clk         rising-edge clock
//   clrn        asynchronous active-low reset (clears registers and dump FSM)
//   rna, rnb    read register numbers
//   qa, qb      read data (combinational)
//   wn, d, we   write register number, write data and write enable
//   dump_start  starts a dump; only sampled while the engine is idle
//   dump_busy   engine not idle (registered)
//   dump_valid  dump_idx/dump_data hold a beat
//   dump_ready  consumer accepts the current beat
//   dump_idx    register number of the current beat
//   dump_data   snapshot of that register
//   dump_done   one-cycle pulse after the last beat
// ============================================================================
module regfile_dump #(
    parameter bit BYPASS    = 1'b1,
    parameter int DUMP_LAST = 31
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [4:0]  rna,
    input  logic [4:0]  rnb,
    output logic [31:0] qa,
    output logic [31:0] qb,
    input  logic [4:0]  wn,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        dump_start,
    output logic        dump_busy,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        dump_done
);

    localparam logic [4:0] LAST_IDX = DUMP_LAST[4:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------------
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        write_hit;

    // Register 0 is hard-wired to zero, so writes to it are dropped here.
    assign write_hit = we && (wn != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (write_hit) begin
            regs_d[wn] = d;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    always_comb begin
        qa = regs_q[rna];
        qb = regs_q[rnb];
        if (BYPASS && write_hit && (wn == rna)) begin
            qa = d;
        end
        if (BYPASS && write_hit && (wn == rnb)) begin
            qb = d;
        end
        if (rna == 5'd0) begin
            qa = '0;
        end
        if (rnb == 5'd0) begin
            qb = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Dump engine
    // ------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [4:0]  dump_idx_q, dump_idx_d;
    logic [31:0] dump_data_q, dump_data_d;
    logic        dump_busy_q, dump_busy_d;
    logic [4:0]  idx_inc;

    always_comb begin
        state_d     = state_q;
        dump_idx_d  = dump_idx_q;
        dump_data_d = dump_data_q;
        idx_inc     = dump_idx_q + 5'd1;

        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    state_d     = S_SEND;
                    dump_idx_d  = 5'd0;
                    dump_data_d = '0;   // register 0 always reads zero
                end
            end
            S_SEND: begin
                if (dump_ready) begin
                    if (dump_idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        dump_idx_d  = idx_inc;
                        // regs_d already carries a write landing on this
                        // edge, so the loaded snapshot sees the new value.
                        dump_data_d = regs_d[idx_inc];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        dump_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= S_IDLE;
            dump_idx_q  <= '0;
            dump_data_q <= '0;
            dump_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dump_idx_q  <= dump_idx_d;
            dump_data_q <= dump_data_d;
            dump_busy_q <= dump_busy_d;
        end
    end

    assign dump_busy  = dump_busy_q;
    assign dump_valid = (state_q == S_SEND);
    assign dump_done  = (state_q == S_DONE);
    assign dump_idx   = dump_idx_q;
    assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_regfile_dump.sv
`timescale 1ns/1ps
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        clrn;
    logic [4:0]  rna, rnb, wn;
    logic [31:0] d;
    logic        we, dump_start, dump_ready;

    logic [31:0] qa1, qb1, data1, qa0, qb0, data0;
    logic        busy1, valid1, done1, busy0, valid0, done0;
    logic [4:0]  idx1, idx0;

    int errors = 0;
    int checks = 0;

    regfile_dump #(.BYPASS(1'b1), .DUMP_LAST(31)) u_byp (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa1), .qb(qb1),
        .wn(wn), .d(d), .we(we), .dump_start(dump_start), .dump_busy(busy1),
        .dump_valid(valid1), .dump_ready(dump_ready), .dump_idx(idx1),
        .dump_data(data1), .dump_done(done1));

    regfile_dump #(.BYPASS(1'b0), .DUMP_LAST(31)) u_nobyp (
        .clk(clk), .clrn(clrn), .rna(rna), .rnb(rnb), .qa(qa0), .qb(qb0),
        .wn(wn), .d(d), .we(we), .dump_start(dump_start), .dump_busy(busy0),
        .dump_valid(valid0), .dump_ready(dump_ready), .dump_idx(idx0),
        .dump_data(data0), .dump_done(done0));

    always #5 clk = ~clk;

    // Reference register contents: what the CPU should see as stored.
    logic [31:0] m [32];
    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 32; i++) m[i] <= '0;
        end else if (we && wn != 5'd0) begin
            m[wn] <= d;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [4:0] n, input logic [31:0] v);
        we = 1'b1; wn = n; d = v;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 1; i < 32; i++) wr(i[4:0], $urandom | 32'h1);
        rna = 5'd9; #1;
        checks++; if (qa1 !== m[9]) begin errors++; $display("FAIL pre_reset_qa: got %h want %h", qa1, m[9]); end
        @(negedge clk);
        clrn = 1'b0;
        #0.5;
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy1); end
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done1); end
        checks++; if (idx1 !== 5'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", idx1); end
        checks++; if (data1 !== 32'd0) begin errors++; $display("FAIL rst_data: got %h want 0", data1); end
        checks++; if (busy0 !== 1'b0 || valid0 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL rst_ctl_nobyp: got %b%b%b want 000", busy0, valid0, done0); end
        checks++; if (idx0 !== 5'd0 || data0 !== 32'd0) begin errors++; $display("FAIL rst_dump_nobyp: got %0d/%h want 0/0", idx0, data0); end
        for (int i = 0; i < 32; i++) begin
            rna = i[4:0]; rnb = 5'(31 - i);
            #0.1;
            checks++; if (qa1 !== 32'd0 || qb1 !== 32'd0) begin errors++; $display("FAIL rst_read_%0d: got %h/%h want 0/0", i, qa1, qb1); end
            checks++; if (qa0 !== 32'd0 || qb0 !== 32'd0) begin errors++; $display("FAIL rst_read_nobyp_%0d: got %h/%h want 0/0", i, qa0, qb0); end
        end
        clrn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_rw();
        logic [31:0] e1a, e1b, e0a, e0b;
        wr(5'd5, 32'h0000000C);
        wr(5'd12, 32'h00000005);
        rna = 5'd5; rnb = 5'd12; #1;
        checks++; if (qa1 !== 32'hC) begin errors++; $display("FAIL basic_qa: got %h want %h", qa1, 32'hC); end
        checks++; if (qb1 !== 32'h5) begin errors++; $display("FAIL basic_qb: got %h want %h", qb1, 32'h5); end
        checks++; if (qa0 !== 32'hC || qb0 !== 32'h5) begin errors++; $display("FAIL basic_nobyp: got %h/%h want c/5", qa0, qb0); end
        @(negedge clk);
        we = 1'b1; wn = 5'd0; d = 32'hFFFFFFFF; rna = 5'd0; #1;
        checks++; if (qa1 !== 32'd0) begin errors++; $display("FAIL r0_write_cycle: got %h want 0", qa1); end
        @(negedge clk);
        we = 1'b0; #1;
        checks++; if (qa1 !== 32'd0) begin errors++; $display("FAIL r0_after_write: got %h want 0", qa1); end
        @(negedge clk);
        for (int it = 0; it < 40; it++) begin
            we = 1'($urandom_range(0, 1)); wn = 5'($urandom); d = $urandom;
            rna = 5'($urandom); rnb = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rna = wn;
            if ($urandom_range(0, 3) == 0) rnb = wn;
            #1;
            e0a = m[rna]; e0b = m[rnb];
            e1a = (we && wn != 0 && wn == rna) ? d : m[rna];
            e1b = (we && wn != 0 && wn == rnb) ? d : m[rnb];
            checks++; if (qa1 !== e1a || qb1 !== e1b) begin errors++; $display("FAIL rand_rw_byp[%0d]: got %h/%h want %h/%h", it, qa1, qb1, e1a, e1b); end
            checks++; if (qa0 !== e0a || qb0 !== e0b) begin errors++; $display("FAIL rand_rw_nobyp[%0d]: got %h/%h want %h/%h", it, qa0, qb0, e0a, e0b); end
            @(negedge clk);
        end
        we = 1'b0;
    endtask

    task automatic test_bypass();
        wr(5'd7, 32'h11);
        we = 1'b1; wn = 5'd7; d = 32'hDEADBEEF; rna = 5'd7; rnb = 5'd7; #1;
        checks++; if (qa1 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_same_cycle: got %h want deadbeef", qa1); end
        checks++; if (qa0 !== 32'h11) begin errors++; $display("FAIL nobypass_same_cycle: got %h want 11", qa0); end
        checks++; if (qb1 !== 32'hDEADBEEF || qb0 !== 32'h11) begin errors++; $display("FAIL bypass_qb: got %h/%h want deadbeef/11", qb1, qb0); end
        @(negedge clk);
        we = 1'b0; #1;
        checks++; if (qa1 !== 32'hDEADBEEF || qa0 !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_next_cycle: got %h/%h want deadbeef", qa1, qa0); end
        @(negedge clk);
    endtask

    task automatic test_full_dump();
        for (int i = 1; i < 32; i++) wr(i[4:0], 32'(3 * i));
        dump_ready = 1'b1; dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            checks++; if (valid1 !== 1'b1 || busy1 !== 1'b1) begin errors++; $display("FAIL full_vld_busy[%0d]: got %b/%b want 1/1", k, valid1, busy1); end
            checks++; if (idx1 !== k[4:0] || data1 !== 32'(3 * k)) begin errors++; $display("FAIL full_beat[%0d]: got %0d/%h want %0d/%h", k, idx1, data1, k, 32'(3 * k)); end
            checks++; if (idx0 !== k[4:0] || data0 !== 32'(3 * k)) begin errors++; $display("FAIL full_beat_nobyp[%0d]: got %0d/%h want %0d/%h", k, idx0, data0, k, 32'(3 * k)); end
            @(negedge clk);
        end
        #1;
        checks++; if (done1 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b1) begin errors++; $display("FAIL full_done: got done=%b vld=%b busy=%b want 1/0/1", done1, valid1, busy1); end
        @(negedge clk);
        #1;
        checks++; if (done1 !== 1'b0 || busy1 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL full_idle: got done=%b busy=%b vld=%b want 0/0/0", done1, busy1, valid1); end
    endtask

    // Starts in the idle cycle right after a completed dump (back-to-back start).
    task automatic test_backpressure();
        int exp_idx, exp_phase, stall;
        logic [31:0] exp_data, exp_qa;
        bit finished, b5chk;
        exp_idx = 0; exp_phase = 0; stall = 0; exp_data = 0; finished = 0; b5chk = 0;
        dump_start = 1'b1; dump_ready = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            we = 1'b0; dump_start = 1'b0; rna = 5'd4; rnb = 5'd5;
            if (exp_phase == 0 && exp_idx < 4) begin
                dump_ready = 1'b1;
            end else if (exp_phase == 0 && exp_idx == 4 && stall < 3) begin
                case (stall)
                    0: begin dump_ready = 1'b0; we = 1'b1; wn = 5'd4; d = 32'hABCD; end
                    1: begin dump_ready = 1'b0; dump_start = 1'b1; end
                    default: begin dump_ready = 1'b1; we = 1'b1; wn = 5'd5; d = 32'h55AA55AA; end
                endcase
                stall++;
            end else begin
                dump_ready = 1'($urandom_range(0, 1));
                we = 1'($urandom_range(0, 1)); wn = 5'($urandom); d = $urandom;
            end
            #1;
            exp_qa = (we && wn == 5'd4) ? d : m[4];
            checks++; if (qa1 !== exp_qa) begin errors++; $display("FAIL bp_cpu_read[%0d]: got %h want %h", cyc, qa1, exp_qa); end
            if (exp_phase == 0) begin
                checks++; if (valid1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL bp_ctl[%0d]: got vld=%b busy=%b done=%b want 1/1/0", cyc, valid1, busy1, done1); end
                checks++; if (idx1 !== exp_idx[4:0] || data1 !== exp_data) begin errors++; $display("FAIL bp_beat[%0d]: got %0d/%h want %0d/%h", cyc, idx1, data1, exp_idx, exp_data); end
                if (exp_idx == 5 && !b5chk) begin
                    b5chk = 1;
                    checks++; if (data1 !== 32'h55AA55AA) begin errors++; $display("FAIL bp_beat5_new: got %h want 55aa55aa", data1); end
                end
            end else if (exp_phase == 1) begin
                checks++; if (done1 !== 1'b1 || valid1 !== 1'b0) begin errors++; $display("FAIL bp_done: got done=%b vld=%b want 1/0", done1, valid1); end
            end else begin
                checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL bp_idle: got busy=%b done=%b want 0/0", busy1, done1); end
                finished = 1;
            end
            if (exp_phase == 0 && dump_ready) begin
                if (exp_idx == 31) exp_phase = 1;
                else begin
                    exp_idx++;
                    exp_data = (we && wn != 0 && wn == exp_idx[4:0]) ? d : m[exp_idx];
                end
            end else if (exp_phase == 1) begin
                exp_phase = 2;
            end
            @(negedge clk);
        end
        we = 1'b0; dump_start = 1'b0;
        checks++; if (!finished) begin errors++; $display("FAIL bp_timeout: got phase %0d want idle", exp_phase); end
    endtask

    task automatic test_reset_mid_dump();
        dump_ready = 1'b1; we = 1'b0; dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        repeat (10) @(negedge clk);
        #0.1;
        checks++; if (idx1 !== 5'd10 || valid1 !== 1'b1) begin errors++; $display("FAIL mid_pre_idx: got %0d/%b want 10/1", idx1, valid1); end
        clrn = 1'b0;
        #0.1;
        checks++; if (busy1 !== 1'b0 || valid1 !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl: got busy=%b vld=%b want 0/0", busy1, valid1); end
        checks++; if (idx1 !== 5'd0 || data1 !== 32'd0 || done1 !== 1'b0) begin errors++; $display("FAIL mid_rst_dump: got %0d/%h/%b want 0/0/0", idx1, data1, done1); end
        for (int i = 1; i < 32; i++) begin
            rna = i[4:0]; #0.1;
            checks++; if (qa1 !== 32'd0) begin errors++; $display("FAIL mid_rst_reg%0d: got %h want 0", i, qa1); end
        end
        clrn = 1'b1;
        @(negedge clk);
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            checks++; if (valid1 !== 1'b1 || idx1 !== k[4:0] || data1 !== 32'd0) begin errors++; $display("FAIL redump[%0d]: got vld=%b %0d/%h want 1 %0d/0", k, valid1, idx1, data1, k); end
            @(negedge clk);
        end
        #1;
        checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL redump_done: got %b want 1", done1); end
        @(negedge clk);
    endtask

    initial begin
        clrn = 1'b0; rna = '0; rnb = '0; wn = '0; d = '0; we = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_rw();
        test_bypass();
        test_full_dump();
        test_backpressure();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

32×32-bit MIPS general-purpose register file for the single-cycle CPU, with two combinational read ports and one write port. The write port takes the 5-bit destination number chosen by the rd/rt destination mux, together with the write-back data. A sequential dump engine streams every register out over a valid/ready handshake, for the board display or the bench scoreboard. It sits between the decode/destination-select logic and the ALU operand inputs.

## Interface
- `BYPASS`, default 1: 1 means a same-cycle write is forwarded to the read ports; 0 means reads return the stored value only.
- `DUMP_LAST`, default 31: index of the last register streamed (range 0..31).

- `clk`  in  1  clock; all state updates on the rising edge.
- `clrn`  in  1  reset, asynchronous, active-low; one clock, no other reset.
- `rna`  in  5  read port A register number.
- `rnb`  in  5  read port B register number.
- `qa`  out  32  read port A data, combinational.
- `qb`  out  32  read port B data, combinational.
- `wn`  in  5  write register number, from the destination mux.
- `d`  in  32  write data.
- `we`  in  1  write enable.
- `dump_start`  in  1  request a register dump; sampled only in IDLE.
- `dump_busy`  out  1  dump engine not in IDLE.
- `dump_valid`  out  1  `dump_idx`/`dump_data` hold a beat.
- `dump_ready`  in  1  consumer accepts the beat.
- `dump_idx`  out  5  register number of the current beat.
- `dump_data`  out  32  snapshot of that register.
- `dump_done`  out  1  one-cycle pulse after the last beat.

## Operation
- Register 0 always reads 0x00000000. Writes with `wn`=0 are discarded.
- Write: on a clock edge with `we`=1 and `wn`≠0, `reg[wn]` ← `d`.
- Read: `qa` = `reg[rna]`, `qb` = `reg[rnb]`.
  - With `BYPASS`=1: when `we`=1, `wn`≠0 and `wn`==`rna`, `qa`=`d`. Same rule for `qb` with `rnb`.
  - Both ports may address the same register.
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE, `dump_start`=1 → SEND. `dump_idx` ← 0 and `dump_data` ← 0.
  - SEND: `dump_valid`=1.
    - On `dump_valid`&&`dump_ready` with `dump_idx`==`DUMP_LAST` → DONE.
    - On `dump_valid`&&`dump_ready` otherwise: `dump_idx` ← `dump_idx`+1 and `dump_data` ← `reg[dump_idx+1]`.
    - The loaded value includes a write to that register in the same cycle (new `d` is taken).
  - DONE: `dump_done`=1 for one cycle → IDLE.
- `dump_data` is a snapshot. A CPU write to the register being presented does not change `dump_data` while `dump_valid` is held.
- `dump_start` is ignored outside IDLE. The dump never stalls or blocks CPU reads or writes.
- Index never wraps; the dump stops at `DUMP_LAST`.

## Timing
- Reset (`clrn`=0) takes effect immediately, asynchronously, including mid-dump:
  - all 32 registers = 0;
  - FSM = IDLE;
  - `dump_busy`=0, `dump_valid`=0, `dump_done`=0, `dump_idx`=0, `dump_data`=0.
- Write latency: the stored value is visible on `qa`/`qb` from the cycle after the write edge. With `BYPASS`=1 it is also visible combinationally in the write cycle.
- Dump with `dump_start` sampled at edge N and `dump_ready` held at 1:
  - `dump_valid` and `dump_busy` are high from cycle N+1;
  - beat k is presented in cycle N+1+k;
  - `dump_done` is high in cycle N+2+`DUMP_LAST`;
  - IDLE is reached at N+3+`DUMP_LAST` and can accept a new start there.
  - Full dump: 32 beats plus 1 done cycle.
- Backpressure: while `dump_valid`=1 and `dump_ready`=0, `dump_idx` and `dump_data` stay stable.
- `dump_busy` = (state ≠ IDLE), registered.

## Test plan
- Reset: pulse `clrn` low mid-cycle with no clock edge → `qa`/`qb` = 0 for all of `rna`/`rnb` 0..31; `dump_busy`/`dump_valid`/`dump_done`/`dump_idx`/`dump_data` = 0.
- Basic write/read: write r5=0x0000000C, then r12=0x00000005. Next cycle `rna`=5, `rnb`=12 → `qa`=0xC, `qb`=0x5. Write r0=0xFFFFFFFF → `rna`=0 still reads 0.
- Bypass: `we`=1, `wn`=7, `d`=0xDEADBEEF, `rna`=7, r7 previously 0x11 → same-cycle `qa`=0xDEADBEEF with `BYPASS`=1, `qa`=0x11 with `BYPASS`=0. Both variants read 0xDEADBEEF the next cycle.
- Full dump: set r1..r31 = 3×index, hold `dump_ready`=1, pulse `dump_start` at edge N → 32 beats, `dump_idx` 0..31, `dump_data` 0,3,…,93 in cycles N+1..N+32, `dump_done` at N+33, IDLE at N+34.
- Backpressure plus snapshot: toggle `dump_ready` 1,0,0,1. While stalled at idx 4, write r4=0xABCD → `dump_idx`=4 and old `dump_data` held through the stall. Concurrently write r5 at the edge that accepts beat 4 → beat 5 shows the new value.
- Reset mid-dump: assert `clrn`=0 while `dump_idx`=10 → `dump_busy`/`dump_valid` drop immediately and all registers clear. Restart the dump → 32 beats of 0x00000000.
